// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg: shared types and constants for the fetch-to-decode instruction queue
package inst_queue_pkg;
    typedef logic [31:0] virt_t;
    typedef logic [31:0] uint32_t;
    typedef struct packed {
        logic       ex;
        logic       tlb_refill;
        logic [4:0] exccode;
    } exception_t;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_TLBL = 5'h02;
    typedef struct packed {
        virt_t      pc;
        uint32_t    inst;
        exception_t ex;
    } inst_queue_entry_t;
    localparam int INST_QUEUE_DEPTH = 16;
endpackage

// File: rtl/inst_queue_if.sv
// inst_queue_if: fetch-side push and decode-side pop bundle of the instruction queue
interface inst_queue_if
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = INST_QUEUE_DEPTH
) ();
    localparam int PTR_W = $clog2(DEPTH);
    logic                   flush;
    logic       [1:0]       enq_valid;
    virt_t      [1:0]       enq_pc;
    uint32_t    [1:0]       enq_inst;
    exception_t [1:0]       enq_ex;
    logic                   enq_ready;
    logic       [1:0]       deq_valid;
    virt_t      [1:0]       deq_pc;
    uint32_t    [1:0]       deq_inst;
    exception_t [1:0]       deq_ex;
    logic       [1:0]       deq_num;
    logic       [PTR_W:0]   count;
    modport master (
        output flush, enq_valid, enq_pc, enq_inst, enq_ex, deq_num,
        input  enq_ready, deq_valid, deq_pc, deq_inst, deq_ex, count
    );
    modport slave (
        input  flush, enq_valid, enq_pc, enq_inst, enq_ex, deq_num,
        output enq_ready, deq_valid, deq_pc, deq_inst, deq_ex, count
    );
endinterface

// File: rtl/inst_queue.sv
// inst_queue: two-wide circular FIFO decoupling fetch from decode, with full flush
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = INST_QUEUE_DEPTH
) (
    input logic       clk,
    input logic       reset,
    inst_queue_if.slave q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - 2);
    localparam logic [PTR_W:0] CNT_TWO = (PTR_W+1)'(2);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    inst_queue_entry_t mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, head1, tail1;
    logic [PTR_W:0]   count_q, count_d;
    logic [1:0]       push_n, avail_n, pop_n;

    // Handshake from registered occupancy, clamped pop, next pointers and head/head+1 read
    always_comb begin
        head1 = head_q + PTR_ONE;
        tail1 = tail_q + PTR_ONE;
        q.enq_ready = count_q <= READY_MAX;
        q.deq_valid = {count_q >= CNT_TWO, count_q != '0};
        q.count = count_q;
        avail_n = count_q >= CNT_TWO ? 2'd2 : count_q[1:0];
        pop_n = q.deq_num > avail_n ? avail_n : q.deq_num;
        push_n = !q.enq_ready ? 2'd0 : q.enq_valid == 2'b11 ? 2'd2 : q.enq_valid == 2'b01 ? 2'd1 : 2'd0;
        head_d = q.flush ? '0 : head_q + PTR_W'(pop_n);
        tail_d = q.flush ? '0 : tail_q + PTR_W'(push_n);
        count_d = q.flush ? '0 : count_q + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);
        q.deq_pc = {mem_q[head1].pc, mem_q[head_q].pc};
        q.deq_inst = {mem_q[head1].inst, mem_q[head_q].inst};
        q.deq_ex = {mem_q[head1].ex, mem_q[head_q].ex};
    end

    // Pointer and occupancy state; full/empty are decided by count, never by pointer compare
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage stays unreset since validity is carried entirely by count_q
    always_ff @(posedge clk) begin
        if (!q.flush && push_n != 2'd0)
            mem_q[tail_q] <= '{pc: q.enq_pc[0], inst: q.enq_inst[0], ex: q.enq_ex[0]};
        if (!q.flush && push_n == 2'd2)
            mem_q[tail1] <= '{pc: q.enq_pc[1], inst: q.enq_inst[1], ex: q.enq_ex[1]};
    end

    a_deq_num: assert property (@(posedge clk) disable iff (reset) q.deq_num <= avail_n);
    a_enq_valid: assert property (@(posedge clk) disable iff (reset) q.enq_valid != 2'b10);
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed stimulus with a queue scoreboard checked on every falling edge
module tb_inst_queue;
    import inst_queue_pkg::*;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    inst_queue_entry_t exp_q[$];

    inst_queue_if #(.DEPTH(DEPTH)) iq ();
    inst_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .q(iq));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic [1:0] ev, input virt_t p0, input virt_t p1,
                        input logic [1:0] dn, input logic fl = 1'b0,
                        input exception_t x1 = '0);
        iq.enq_valid = ev;
        iq.enq_pc = {p1, p0};
        iq.enq_inst = {~p1, ~p0};
        iq.enq_ex = {x1, exception_t'('0)};
        iq.deq_num = dn;
        iq.flush = fl;
        @(posedge clk);
        #1;
        iq.enq_valid = 2'b00;
        iq.deq_num = 2'd0;
        iq.flush = 1'b0;
    endtask

    // Scoreboard update: pops what decode consumed, then appends what fetch pushed if there was room
    always @(posedge clk or posedge reset) begin
        int n;
        if (reset || iq.flush) exp_q.delete();
        else begin
            n = exp_q.size();
            for (int i = 0; i < int'(iq.deq_num) && exp_q.size() > 0; i++) void'(exp_q.pop_front());
            if (n <= DEPTH - 2 && (iq.enq_valid == 2'b01 || iq.enq_valid == 2'b11))
                exp_q.push_back('{pc: iq.enq_pc[0], inst: iq.enq_inst[0], ex: iq.enq_ex[0]});
            if (n <= DEPTH - 2 && iq.enq_valid == 2'b11)
                exp_q.push_back('{pc: iq.enq_pc[1], inst: iq.enq_inst[1], ex: iq.enq_ex[1]});
        end
    end

    // Monitor: compares whatever the queue presents against the oldest scoreboard entries
    always @(negedge clk) begin
        if (!reset) begin
            chk("mon_count", 64'(iq.count), 64'(exp_q.size()));
            chk("mon_enq_ready", 64'(iq.enq_ready), 64'(exp_q.size() <= DEPTH - 2));
            chk("mon_deq_valid", 64'(iq.deq_valid), 64'({exp_q.size() >= 2, exp_q.size() >= 1}));
            for (int i = 0; i < 2; i++) begin
                if (i < exp_q.size()) begin
                    chk("mon_deq_pc", 64'(iq.deq_pc[i]), 64'(exp_q[i].pc));
                    chk("mon_deq_inst", 64'(iq.deq_inst[i]), 64'(exp_q[i].inst));
                    chk("mon_deq_ex", 64'(iq.deq_ex[i]), 64'(exp_q[i].ex));
                end
            end
        end
    end

    initial begin
        iq.flush = 1'b0;
        iq.enq_valid = 2'b00;
        iq.enq_pc = '0;
        iq.enq_inst = '0;
        iq.enq_ex = '0;
        iq.deq_num = 2'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_count", 64'(iq.count), 64'd0);
        chk("rst_enq_ready", 64'(iq.enq_ready), 64'd1);
        chk("rst_deq_valid", 64'(iq.deq_valid), 64'd0);

        step(2'b11, 32'h100, 32'h104, 2'd0);
        step(2'b11, 32'h108, 32'h10C, 2'd0);
        step(2'b01, 32'h110, 32'h0, 2'd0);
        chk("pre_reset_count", 64'(iq.count), 64'd5);
        #3 reset = 1'b1;
        #1;
        chk("async_rst_deq_valid", 64'(iq.deq_valid), 64'd0);
        chk("async_rst_count", 64'(iq.count), 64'd0);
        chk("async_rst_enq_ready", 64'(iq.enq_ready), 64'd1);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int k = 0; k < 8; k++) step(2'b11, 32'h8000_0000 + 32'(8 * k), 32'h8000_0004 + 32'(8 * k), 2'd0);
        chk("fill_count", 64'(iq.count), 64'd16);
        chk("fill_enq_ready", 64'(iq.enq_ready), 64'd0);
        chk("fill_deq_valid", 64'(iq.deq_valid), 64'd3);
        chk("fill_deq_pc0", 64'(iq.deq_pc[0]), 64'h8000_0000);
        chk("fill_deq_pc1", 64'(iq.deq_pc[1]), 64'h8000_0004);
        step(2'b11, 32'hDEAD_0000, 32'hDEAD_0004, 2'd0);
        chk("full_push_ignored", 64'(iq.count), 64'd16);
        repeat (8) step(2'b00, 32'h0, 32'h0, 2'd2);
        chk("drain_count", 64'(iq.count), 64'd0);

        step(2'b11, 32'h1000, 32'h1004, 2'd0);
        step(2'b11, 32'h1008, 32'h100C, 2'd0);
        step(2'b11, 32'h1010, 32'h1014, 2'd2);
        chk("simul_count", 64'(iq.count), 64'd4);
        chk("simul_deq_pc0", 64'(iq.deq_pc[0]), 64'h1008);
        chk("simul_deq_pc1", 64'(iq.deq_pc[1]), 64'h100C);
        repeat (2) step(2'b00, 32'h0, 32'h0, 2'd2);

        step(2'b01, 32'h1500, 32'h0, 2'd0);
        for (int k = 0; k < 8; k++) step(2'b01, 32'h1504 + 32'(4 * k), 32'h0, 2'd1);
        step(2'b00, 32'h0, 32'h0, 2'd1);
        chk("pre_wrap_count", 64'(iq.count), 64'd0);
        step(2'b11, 32'h2000, 32'h2004, 2'd0);
        chk("wrap_count", 64'(iq.count), 64'd2);
        chk("wrap_deq_pc0", 64'(iq.deq_pc[0]), 64'h2000);
        chk("wrap_deq_pc1", 64'(iq.deq_pc[1]), 64'h2004);
        step(2'b00, 32'h0, 32'h0, 2'd2);
        chk("wrap_pop_count", 64'(iq.count), 64'd0);
        chk("wrap_pop_valid", 64'(iq.deq_valid), 64'd0);

        step(2'b11, 32'h3000, 32'h3004, 2'd0);
        step(2'b11, 32'h3008, 32'h300C, 2'd0);
        step(2'b11, 32'h3010, 32'h3014, 2'd0);
        chk("pre_flush_count", 64'(iq.count), 64'd6);
        step(2'b11, 32'h4000, 32'h4004, 2'd2, 1'b1);
        chk("flush_count", 64'(iq.count), 64'd0);
        chk("flush_deq_valid", 64'(iq.deq_valid), 64'd0);
        repeat (2) step(2'b00, 32'h0, 32'h0, 2'd0);
        chk("flush_stays_empty", 64'(iq.deq_valid), 64'd0);

        step(2'b11, 32'hBFC0_0000, 32'hBFC0_0004, 2'd0, 1'b0,
             exception_t'{ex: 1'b1, tlb_refill: 1'b0, exccode: EXC_ADEL});
        chk("exc_deq_pc1", 64'(iq.deq_pc[1]), 64'hBFC0_0004);
        chk("exc_deq_ex1", 64'(iq.deq_ex[1]), 64'h44);
        chk("exc_deq_ex0", 64'(iq.deq_ex[0]), 64'h0);
        step(2'b00, 32'h0, 32'h0, 2'd2);
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
